// File: rtl/modbus_tx_seq_pkg.sv
// Shared types and constants for the Modbus RTU transmit sequencer.
// The CRC constants describe the external engine and are used by its models.
package modbus_seq_pkg;

    localparam int unsigned CRC_CYCLES_DEF = 17;
    localparam logic [15:0] CRC_INIT_VAL   = 16'hFFFF;
    localparam logic [15:0] CRC_POLY_REFL  = 16'hA001;

    typedef enum logic [2:0] {
        ST_SETTLE,
        ST_IDLE,
        ST_INIT,
        ST_WAIT_BYTE,
        ST_XFER,
        ST_CRC_LO,
        ST_CRC_HI,
        ST_GAP
    } seq_state_e;

    function automatic int unsigned umax(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/modbus_tx_seq_timer.sv
// Loadable down-counter with a done flag; shared by the settle, byte-wait and gap phases.
// The reset value lets the counter start timing straight out of reset.
module seq_timer #(
    parameter int unsigned     W       = 12,
    parameter logic [W-1:0]    RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/modbus_tx_seq.sv
// Modbus RTU frame transmit sequencer: drives the external bit-serial CRC16 engine,
// forwards payload to the UART, appends CRC low/high and enforces the inter-frame gap.
module modbus_tx_seq
    import modbus_seq_pkg::*;
#(
    parameter int unsigned CRC_CYCLES = CRC_CYCLES_DEF,
    parameter int unsigned GAP_CYCLES = 3500,
    parameter int unsigned LEN_W      = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             s_ready,
    output logic             tx_valid,
    output logic [7:0]       tx_data,
    input  logic             tx_ready,
    output logic             crc_init,
    output logic             crc_load,
    output logic [7:0]       crc_byte,
    input  logic [7:0]       crc_l,
    input  logic [7:0]       crc_h,
    output logic             busy,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len
);

    localparam int unsigned     TMR_W    = $clog2(umax(CRC_CYCLES, GAP_CYCLES) + 1);
    localparam logic [TMR_W-1:0] CRC_WAIT = TMR_W'(CRC_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_WAIT = TMR_W'(GAP_CYCLES - 1);

    seq_state_e       state_q;
    logic             s_ready_q;
    logic             tx_valid_q;
    logic [7:0]       hold_q;
    logic             crc_init_q;
    logic             crc_load_q;
    logic [7:0]       crc_byte_q;
    logic             last_q;
    logic             sent_q;
    logic             frame_done_q;
    logic [LEN_W-1:0] frame_len_q;

    logic             s_hs;
    logic             tx_acc;
    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_done;

    assign s_hs   = s_valid & s_ready_q;
    assign tx_acc = tx_valid_q & tx_ready;

    // Out of reset the timer already holds CRC_WAIT, so SETTLE covers any engine shift in flight.
    seq_timer #(
        .W       (TMR_W),
        .RST_VAL (CRC_WAIT)
    ) u_timer (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .done_o  (tmr_done)
    );

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = CRC_WAIT;
        if (state_q == ST_WAIT_BYTE && s_hs) begin
            tmr_load = 1'b1;
        end else if (state_q == ST_CRC_HI && tx_acc) begin
            tmr_load = 1'b1;
            tmr_val  = GAP_WAIT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SETTLE;
            s_ready_q    <= 1'b0;
            tx_valid_q   <= 1'b0;
            hold_q       <= '0;
            crc_init_q   <= 1'b0;
            crc_load_q   <= 1'b0;
            crc_byte_q   <= '0;
            last_q       <= 1'b0;
            sent_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
        end else begin
            crc_init_q   <= 1'b0;
            crc_load_q   <= 1'b0;
            frame_done_q <= 1'b0;
            unique case (state_q)
                ST_SETTLE: begin
                    if (tmr_done) state_q <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (s_valid) begin
                        crc_init_q <= 1'b1;
                        state_q    <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    frame_len_q <= '0;
                    s_ready_q   <= 1'b1;
                    state_q     <= ST_WAIT_BYTE;
                end
                ST_WAIT_BYTE: begin
                    if (s_hs) begin
                        s_ready_q  <= 1'b0;
                        hold_q     <= s_data;
                        crc_byte_q <= s_data;
                        last_q     <= s_last;
                        if (frame_len_q != '1) frame_len_q <= frame_len_q + 1'b1;
                        tx_valid_q <= 1'b1;
                        sent_q     <= 1'b0;
                        crc_load_q <= 1'b1;
                        state_q    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (tx_acc) begin
                        tx_valid_q <= 1'b0;
                        sent_q     <= 1'b1;
                    end
                    // Leave only once the UART has the byte and the engine result has settled.
                    if (tmr_done && (sent_q || tx_acc)) begin
                        if (last_q) begin
                            tx_valid_q <= 1'b1;
                            state_q    <= ST_CRC_LO;
                        end else begin
                            s_ready_q <= 1'b1;
                            state_q   <= ST_WAIT_BYTE;
                        end
                    end
                end
                ST_CRC_LO: begin
                    if (tx_acc) state_q <= ST_CRC_HI;
                end
                ST_CRC_HI: begin
                    if (tx_acc) begin
                        tx_valid_q   <= 1'b0;
                        frame_done_q <= 1'b1;
                        state_q      <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (tmr_done) state_q <= ST_IDLE;
                end
                default: state_q <= ST_SETTLE;
            endcase
        end
    end

    // CRC bytes come straight from the engine, which holds its result until the next load.
    always_comb begin
        tx_data = hold_q;
        if (state_q == ST_CRC_LO) begin
            tx_data = crc_l;
        end else if (state_q == ST_CRC_HI) begin
            tx_data = crc_h;
        end
    end

    assign s_ready    = s_ready_q;
    assign tx_valid   = tx_valid_q;
    assign crc_init   = crc_init_q;
    assign crc_load   = crc_load_q;
    assign crc_byte   = crc_byte_q;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;

endmodule
